board_seeder: RTL and testbench
===============================

BOARD_SEEDER -- requirements
Module: board_seeder

Interface
REQ-001 Parameter ROWS, default 32, board height in cells.
REQ-002 Parameter COLS, default 32, board width in cells; SHALL be a multiple of 16.
REQ-003 Derived constant WORDS = ROWS*COLS/16; AW = clog2(WORDS), minimum 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to seed the board.
REQ-007 seed  input  16  LFSR seed, sampled on the start cycle.
REQ-008 lfsr_load  output  1  load strobe to the external 16-bit LFSR.
REQ-009 lfsr_seed  output  16  seed value driven to the LFSR.
REQ-010 lfsr_word  input  16  current LFSR output; the LFSR advances every clk while not loading.
REQ-011 wr_valid  output  1  board-memory write request.
REQ-012 wr_ready  input  1  board memory accepts the write.
REQ-013 wr_addr  output  AW  word address, row-major, 16 cells per word.
REQ-014 wr_data  output  16  cell states; bit i is cell (addr*16+i); 1 means alive.
REQ-015 busy  output  1  high from the cycle after an accepted start until done.
REQ-016 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, FETCH, WRITE and FIN.
REQ-018 IDLE: start=1 -> LOAD; seed is latched and 16'h0000 is replaced by 16'h0001 (the all-zero LFSR lock-up state).
REQ-019 LOAD: lfsr_load=1 and lfsr_seed=latched seed for exactly 2 cycles, then -> FETCH.
REQ-020 FETCH: the word is captured from lfsr_word in 1 cycle (in 25 % mode, 2 cycles), then -> WRITE.
REQ-021 WRITE: wr_valid=1 with wr_addr and wr_data held stable until the cycle with wr_valid&&wr_ready.
REQ-022 On acceptance with wr_addr<WORDS-1: wr_addr increments and the FSM -> FETCH.
REQ-023 On acceptance with wr_addr=WORDS-1: -> FIN; wr_addr wraps to 0.
REQ-024 FIN: done=1 for one cycle, then -> IDLE.
REQ-025 Latency: start at cycle N gives lfsr_load in N+1..N+2, capture in N+3 and wr_valid first high in N+4 (50 % mode).
REQ-026 start while busy SHALL be ignored; start in the FIN cycle SHALL be ignored.
REQ-027 wr_ready held low SHALL stall indefinitely with no word skipped or duplicated.
REQ-028 Exactly WORDS writes occur per start; addresses run 0..WORDS-1 in order.

Reset
REQ-029 rst_n low SHALL force IDLE immediately, including mid-operation; the interrupted run is abandoned and done is not pulsed.
REQ-030 Reset values: lfsr_load=0, lfsr_seed=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0.

Configuration
REQ-031 Macro BOARD_SEEDER_DENSITY25_EN is the single compiled-in/out feature.
REQ-032 Defined: FETCH captures 2 consecutive lfsr_word values and writes their bitwise AND (about 25 % live cells); first wr_valid is at N+5.
REQ-033 Undefined: FETCH captures a single word and writes it directly (about 50 % live cells).

Structure
REQ-034 lifegame_pkg SHALL hold LFSR_W=16, CELLS_PER_WORD=16 and the seeder state enum.
REQ-035 There is no sub-module; the LFSR stays external and is connected by the board top.

Verification
REQ-036 ROWS=4, COLS=16, seed=1, wr_ready=1 -> lfsr_load high exactly 2 cycles; 4 writes at addr 0,1,2,3 with wr_data equal to successive LFSR words; done one cycle after the addr-3 write; busy low afterwards.
REQ-037 seed=0 -> lfsr_seed=16'h0001 during LOAD; write data identical to the seed=1 run.
REQ-038 wr_ready low for 5 cycles on addr 1 -> wr_addr and wr_data stable throughout; total writes still 4; no gaps or duplicates.
REQ-039 rst_n asserted while in WRITE at addr 2 -> all outputs at reset values asynchronously; no done pulse; a later start restarts from addr 0.
REQ-040 Second start pulse at addr 1 -> ignored; exactly 4 writes and 1 done pulse.
REQ-041 BOARD_SEEDER_DENSITY25_EN defined, seed=1 -> each wr_data equals the AND of 2 consecutive LFSR words; first wr_valid at N+5.

Source files
------------

// File: rtl/lifegame_pkg.sv
// -----------------------------------------------------------------------------
// lifegame_pkg
// Shared constants and types for the Game-of-Life board blocks.
//   LFSR_W          width of the external pseudo-random generator word
//   CELLS_PER_WORD  board cells packed into one memory word
//   seeder_state_e  board_seeder FSM state encoding (also exported for debug)
//   seed_fix()      maps the all-zero LFSR lock-up seed to 16'h0001
// -----------------------------------------------------------------------------
package lifegame_pkg;

   localparam int LFSR_W         = 16;
   localparam int CELLS_PER_WORD = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FETCH = 3'd2,
      ST_WRITE = 3'd3,
      ST_FIN   = 3'd4
   } seeder_state_e;

   // An all-zero seed would freeze the LFSR forever, so substitute 1.
   function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
      return (s == '0) ? LFSR_W'(1) : s;
   endfunction

endpackage

// File: rtl/board_seeder.sv
// -----------------------------------------------------------------------------
// board_seeder
// Fills the Game-of-Life board memory with pseudo-random cells taken from an
// external 16-bit LFSR. One start request seeds the LFSR, then writes every
// board word once, in address order, and pulses done.
//
// Parameters
//   ROWS, COLS   board size in cells (COLS a multiple of 16)
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle seeding request (ignored unless idle)
//   seed         LFSR seed, sampled with start
//   lfsr_load    load strobe to the external LFSR (2 cycles)
//   lfsr_seed    seed value presented to the LFSR
//   lfsr_word    current LFSR output word
//   wr_valid     board write request
//   wr_ready     board memory accepts the write
//   wr_addr      word address, row-major
//   wr_data      16 cell states, bit i = cell addr*16+i, 1 = alive
//   busy         seeding in progress
//   done         one-cycle pulse after the last word is accepted
//   dbg_state_o  current FSM state, for observation only
//
// Handshake: a write transfers on a cycle where wr_valid && wr_ready are both
// high; while wr_valid is high and wr_ready low, wr_addr and wr_data hold.
//
// Build option: define BOARD_SEEDER_DENSITY25_EN to write the AND of two
// consecutive LFSR words (about 25 % live cells) instead of one word (50 %).
// -----------------------------------------------------------------------------
module board_seeder
   import lifegame_pkg::*;
#(
   parameter  int ROWS  = 32,
   parameter  int COLS  = 32,
   localparam int WORDS = ROWS * COLS / CELLS_PER_WORD,
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LFSR_W-1:0] seed,
   output logic              lfsr_load,
   output logic [LFSR_W-1:0] lfsr_seed,
   input  logic [LFSR_W-1:0] lfsr_word,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [AW-1:0]     wr_addr,
   output logic [LFSR_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output seeder_state_e     dbg_state_o
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

   seeder_state_e     state_q;
   logic              load_cnt_q;   // second LOAD cycle marker
   logic              lfsr_load_q;
   logic [LFSR_W-1:0] lfsr_seed_q;
   logic              wr_valid_q;
   logic [AW-1:0]     wr_addr_q;
   logic [LFSR_W-1:0] wr_data_q;
   logic              busy_q;
   logic              done_q;
`ifdef BOARD_SEEDER_DENSITY25_EN
   logic              fetch_second_q; // first of the two words already held
   logic [LFSR_W-1:0] word_q;
`endif

   // Single-process FSM; every output is a register updated on the
   // transition into the state that owns it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         load_cnt_q     <= 1'b0;
         lfsr_load_q    <= 1'b0;
         lfsr_seed_q    <= '0;
         wr_valid_q     <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
`ifdef BOARD_SEEDER_DENSITY25_EN
         fetch_second_q <= 1'b0;
         word_q         <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q     <= ST_LOAD;
                  lfsr_seed_q <= seed_fix(seed);
                  lfsr_load_q <= 1'b1;
                  load_cnt_q  <= 1'b0;
                  wr_addr_q   <= '0;
                  busy_q      <= 1'b1;
               end
            end

            ST_LOAD: begin
               if (load_cnt_q) begin
                  state_q     <= ST_FETCH;
                  lfsr_load_q <= 1'b0;
`ifdef BOARD_SEEDER_DENSITY25_EN
                  fetch_second_q <= 1'b0;
`endif
               end else begin
                  load_cnt_q <= 1'b1;
               end
            end

            ST_FETCH: begin
`ifdef BOARD_SEEDER_DENSITY25_EN
               if (!fetch_second_q) begin
                  word_q         <= lfsr_word;
                  fetch_second_q <= 1'b1;
               end else begin
                  wr_data_q  <= word_q & lfsr_word;
                  wr_valid_q <= 1'b1;
                  state_q    <= ST_WRITE;
               end
`else
               wr_data_q  <= lfsr_word;
               wr_valid_q <= 1'b1;
               state_q    <= ST_WRITE;
`endif
            end

            ST_WRITE: begin
               if (wr_ready) begin
                  wr_valid_q <= 1'b0;
                  if (wr_addr_q == LAST_ADDR) begin
                     // Last word accepted: address wraps for the next run.
                     wr_addr_q <= '0;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     state_q   <= ST_FIN;
                  end else begin
                     wr_addr_q <= wr_addr_q + AW'(1);
                     state_q   <= ST_FETCH;
`ifdef BOARD_SEEDER_DENSITY25_EN
                     fetch_second_q <= 1'b0;
`endif
                  end
               end
            end

            ST_FIN: begin
               // start is deliberately not looked at here.
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               state_q     <= ST_IDLE;
               lfsr_load_q <= 1'b0;
               wr_valid_q  <= 1'b0;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
            end
         endcase
      end
   end

   assign lfsr_load   = lfsr_load_q;
   assign lfsr_seed   = lfsr_seed_q;
   assign wr_valid    = wr_valid_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_board_seeder.sv
// -----------------------------------------------------------------------------
// tb_board_seeder
// Directed bench for board_seeder on a 4x16 board (4 words). Provides the
// external LFSR (x^16+x^14+x^13+x^11+1, Fibonacci) and a board memory whose
// ready can be held low for a number of cycles on address 1.
// -----------------------------------------------------------------------------
module tb_board_seeder;
   import lifegame_pkg::*;

   localparam int ROWS  = 4;
   localparam int COLS  = 16;
   localparam int WORDS = 4;
   localparam int AW    = 2;
   localparam int STALL = 5;
`ifdef BOARD_SEEDER_DENSITY25_EN
   localparam int FIRST_LAT = 5;
`else
   localparam int FIRST_LAT = 4;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [15:0]   seed;
   logic          lfsr_load;
   logic [15:0]   lfsr_seed;
   logic [15:0]   lfsr_word;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic          busy;
   logic          done;
   seeder_state_e dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   board_seeder #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .seed        (seed),
      .lfsr_load   (lfsr_load),
      .lfsr_seed   (lfsr_seed),
      .lfsr_word   (lfsr_word),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .done        (done),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- external LFSR model ----------------
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int n);
      logic [15:0] r;
      r = s;
      for (int i = 0; i < n; i++) r = lfsr_step(r);
      return r;
   endfunction

   logic [15:0] lfsr_q = 16'hACE1;
   always @(posedge clk) begin
      if (lfsr_load) lfsr_q <= lfsr_seed;
      else           lfsr_q <= lfsr_step(lfsr_q);
   end
   assign lfsr_word = lfsr_q;

   // ---------------- board memory ready model ----------------
   logic stall_en = 1'b0;
   int   stall_cnt = 0;
   always @(posedge clk) begin
      if (!stall_en)                 stall_cnt <= 0;
      else if (wr_valid && !wr_ready) stall_cnt <= stall_cnt + 1;
   end
   assign wr_ready = !(stall_en && wr_valid && (wr_addr == 2'd1) && (stall_cnt < STALL));

   // Expected word k: LFSR equals the seed in the first FETCH cycle and
   // steps once per clock; each word costs 2 cycles (3 in 25 % mode), and
   // a stall delays all later captures by its length.
   function automatic logic [15:0] exp_word(input logic [15:0] s, input int k, input int extra);
`ifdef BOARD_SEEDER_DENSITY25_EN
      return lfsr_adv(s, 3 * k + extra) & lfsr_adv(s, 3 * k + extra + 1);
`else
      return lfsr_adv(s, 2 * k + extra);
`endif
   endfunction

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_lfsr_load"}, 32'(lfsr_load), 32'd0);
      chk({tag, "_lfsr_seed"}, 32'(lfsr_seed), 32'd0);
      chk({tag, "_wr_valid"},  32'(wr_valid),  32'd0);
      chk({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
      chk({tag, "_wr_data"},   32'(wr_data),   32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_done"},      32'(done),      32'd0);
      chk({tag, "_state"},     32'(dbg_state), 32'(ST_IDLE));
   endtask

   // ---------------- table-driven runs ----------------
   typedef struct {
      logic [15:0] sd;        // seed driven with start
      bit          stall;     // hold ready low STALL cycles on addr 1
      bit          dup_start; // extra start pulse during addr-1 write
      bit          fin_start; // start pulse in the FIN (done) cycle
      logic [15:0] exp_seed;  // seed the LFSR must receive
   } vec_t;

   task automatic run_case(input vec_t v, input int idx);
      logic [15:0]   exp_q[$];
      int            rel, first_valid_rel, done_rel, last_acc_rel;
      int            n_wr, n_done, n_load;
      bit            start_pulse, prev_stall, stable_ok, busy_ok;
      logic [AW-1:0] prev_addr;
      logic [15:0]   prev_data;
      string         t;

      t = $sformatf("v%0d", idx);
      for (int k = 0; k < WORDS; k++)
         exp_q.push_back(exp_word(v.exp_seed, k, (v.stall && k >= 2) ? STALL : 0));
      first_valid_rel = -1; done_rel = -1; last_acc_rel = -1;
      n_wr = 0; n_done = 0; n_load = 0;
      start_pulse = 0; prev_stall = 0; stable_ok = 1; busy_ok = 1;
      prev_addr = '0; prev_data = '0;
      stall_en = v.stall;

      @(posedge clk); #1 start = 1'b1; seed = v.sd;
      @(posedge clk); #1 start = 1'b0; seed = 16'hDEAD;

      rel = 0;
      while (rel < 150 && (done_rel < 0 || rel < done_rel + 3)) begin
         @(negedge clk);
         rel++;
         if (start_pulse) begin start = 1'b0; start_pulse = 0; end
         if (lfsr_load) n_load++;
         if (rel == 1 || rel == 2) begin
            chk({t, "_load_high"}, 32'(lfsr_load), 32'd1);
            chk({t, "_lfsr_seed"}, 32'(lfsr_seed), 32'(v.exp_seed));
         end
         if (wr_valid && first_valid_rel < 0) first_valid_rel = rel;
         if (wr_valid && !busy) busy_ok = 0;
         if (prev_stall && !(wr_valid && wr_addr == prev_addr && wr_data == prev_data)) stable_ok = 0;
         prev_stall = wr_valid && !wr_ready;
         prev_addr  = wr_addr;
         prev_data  = wr_data;
         if (wr_valid && wr_ready) begin
            last_acc_rel = rel;
            if (exp_q.size() > 0) begin
               chk({t, "_wr_addr"}, 32'(wr_addr), 32'(n_wr));
               chk({t, "_wr_data"}, 32'(wr_data), 32'(exp_q.pop_front()));
            end
            n_wr++;
            if (v.dup_start && wr_addr == 2'd1) begin start = 1'b1; start_pulse = 1; end
         end else if (v.dup_start && wr_valid && wr_addr == 2'd1 && !start_pulse) begin
            start = 1'b1; start_pulse = 1;
         end
         if (done) begin
            n_done++;
            if (done_rel < 0) done_rel = rel;
            if (v.fin_start) begin start = 1'b1; start_pulse = 1; end
         end
         if (done_rel >= 0 && rel == done_rel + 1) begin
            chk({t, "_busy_after_done"}, 32'(busy), 32'd0);
            chk({t, "_idle_after_done"}, 32'(dbg_state), 32'(ST_IDLE));
         end
      end
      start = 1'b0;
      stall_en = 1'b0;

      chk({t, "_done_seen"},    32'(done_rel >= 0), 32'd1);
      chk({t, "_n_writes"},     32'(n_wr), 32'(WORDS));
      chk({t, "_n_done"},       32'(n_done), 32'd1);
      chk({t, "_n_load"},       32'(n_load), 32'd2);
      chk({t, "_first_valid"},  32'(first_valid_rel), 32'(FIRST_LAT));
      chk({t, "_done_timing"},  32'(done_rel), 32'(last_acc_rel + 1));
      chk({t, "_busy_in_write"}, 32'(busy_ok), 32'd1);
      if (v.stall) chk({t, "_stall_stable"}, 32'(stable_ok), 32'd1);
   endtask

   // Reset asserted during the addr-2 write: outputs clear at once, no done.
   task automatic reset_mid_run();
      bit found;
      int n_done;
      found = 0; n_done = 0;
      @(posedge clk); #1 start = 1'b1; seed = 16'h5A5A;
      @(posedge clk); #1 start = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
         @(negedge clk);
         if (done) n_done++;
         if (wr_valid && wr_addr == 2'd2) found = 1;
      end
      chk("mid_reach_addr2", 32'(found), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid_rst");
      repeat (3) begin @(negedge clk); if (done) n_done++; end
      rst_n = 1'b1;
      repeat (4) begin @(negedge clk); if (done) n_done++; end
      chk("mid_no_done", 32'(n_done), 32'd0);
      chk("mid_idle_after", 32'(dbg_state), 32'(ST_IDLE));
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{sd: 16'h0001, stall: 1'b0, dup_start: 1'b0, fin_start: 1'b0, exp_seed: 16'h0001};
      vecs[1] = '{sd: 16'h0000, stall: 1'b0, dup_start: 1'b0, fin_start: 1'b0, exp_seed: 16'h0001};
      vecs[2] = '{sd: 16'hACE1, stall: 1'b1, dup_start: 1'b0, fin_start: 1'b0, exp_seed: 16'hACE1};
      vecs[3] = '{sd: 16'h1234, stall: 1'b0, dup_start: 1'b1, fin_start: 1'b0, exp_seed: 16'h1234};
      vecs[4] = '{sd: 16'hBEEF, stall: 1'b1, dup_start: 1'b1, fin_start: 1'b1, exp_seed: 16'hBEEF};

      // reset block
      rst_n = 1'b1; start = 1'b0; seed = 16'h0000;
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("por");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_no_start", 32'(busy), 32'd0);

      for (int i = 0; i < 5; i++) run_case(vecs[i], i);

      reset_mid_run();
      // After the abandoned run a fresh start must begin again at address 0.
      run_case(vecs[0], 5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Absolute time guard so the bench always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
